// File: rtl/axi_mem_responder.sv
// AXI slave backed by a byte-strobed word memory, serving one burst at a time.
// Optional post-write snoop request enabled by `define AXI_MEM_RESPONDER_SNOOP_EN.
module axi_mem_responder #(
    parameter int          ID_WIDTH   = 13,
    parameter int          ADDR_WIDTH = 64,
    parameter int          DATA_WIDTH = 64,
    parameter int          MEM_WORDS  = 4096,
    parameter logic [63:0] BASE_ADDR  = 64'h8000_0000,
    localparam int         STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ID_WIDTH-1:0]   s_axi_awid,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic [7:0]            s_axi_awlen,
    input  logic [2:0]            s_axi_awsize,
    input  logic [1:0]            s_axi_awburst,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [DATA_WIDTH-1:0] s_axi_wdata,
    input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
    input  logic                  s_axi_wlast,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [ID_WIDTH-1:0]   s_axi_bid,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic                  s_axi_acvalid,
    output logic [ADDR_WIDTH-1:0] s_axi_acaddr,
    output logic [3:0]            s_axi_acsnoop,
    input  logic                  s_axi_acready
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [ADDR_WIDTH-1:0] LP_BASE = BASE_ADDR[ADDR_WIDTH-1:0];
    localparam logic [ADDR_WIDTH-1:0] LP_SPAN = ADDR_WIDTH'(64'(MEM_WORDS) << 3);

`ifdef AXI_MEM_RESPONDER_SNOOP_EN
    typedef enum logic [2:0] {ST_IDLE, ST_RD_DATA, ST_WR_DATA, ST_WR_RESP, ST_SNOOP} state_t;
`else
    typedef enum logic [2:0] {ST_IDLE, ST_RD_DATA, ST_WR_DATA, ST_WR_RESP} state_t;
`endif

    // Offset compare avoids overflow of BASE+SPAN at the top of the address space.
    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        return (addr >= LP_BASE) && ((addr - LP_BASE) < LP_SPAN);
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_WIDTH-1:0] addr);
        logic [ADDR_WIDTH-1:0] off;
        off = addr - LP_BASE;
        return off[IDX_W+2:3];
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] next_addr(
        input logic [ADDR_WIDTH-1:0] addr,
        input logic [2:0]            size,
        input logic [7:0]            len,
        input logic [1:0]            burst
    );
        logic [ADDR_WIDTH-1:0] step;
        logic [ADDR_WIDTH-1:0] mask;
        step = ADDR_WIDTH'(1) << size;
        mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << size) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   return addr;
            2'b10:   return (addr & ~mask) | ((addr + step) & mask);
            default: return addr + step;
        endcase
    endfunction

    state_t                r_state;
    logic [ID_WIDTH-1:0]   r_id;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [7:0]            r_len;
    logic [2:0]            r_size;
    logic [1:0]            r_burst;
    logic [7:0]            r_beat;
    logic                  r_wr_err;
    logic                  r_awready;
    logic                  r_arready;
    logic                  r_wready;
    logic                  r_bvalid;
    logic [ID_WIDTH-1:0]   r_bid;
    logic [1:0]            r_bresp;
    logic                  r_rvalid;
    logic [ID_WIDTH-1:0]   r_rid;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [1:0]            r_rresp;
    logic                  r_rlast;
    logic [DATA_WIDTH-1:0] r_mem [MEM_WORDS];

`ifdef AXI_MEM_RESPONDER_SNOOP_EN
    logic                  r_acvalid;
    logic [ADDR_WIDTH-1:0] r_acaddr;
    logic [3:0]            r_acsnoop;
    logic [ADDR_WIDTH-1:0] r_aw_first;
`endif

    logic                  w_aw_hs;
    logic                  w_ar_hs;
    logic                  w_w_hs;
    logic                  w_r_hs;
    logic [ADDR_WIDTH-1:0] w_addr_next;
    logic [ADDR_WIDTH-1:0] w_rd_addr;
    logic                  w_rd_ok;
    logic [DATA_WIDTH-1:0] w_rd_word;
    logic                  w_wr_ok;

    // A pending write masks arready so both channels never handshake together.
    assign s_axi_awready = r_awready;
    assign s_axi_arready = r_arready & ~s_axi_awvalid;
    assign s_axi_wready  = r_wready;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bid     = r_bid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rid     = r_rid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign s_axi_rlast   = r_rlast;

`ifdef AXI_MEM_RESPONDER_SNOOP_EN
    assign s_axi_acvalid = r_acvalid;
    assign s_axi_acaddr  = r_acaddr;
    assign s_axi_acsnoop = r_acsnoop;
`else
    assign s_axi_acvalid = 1'b0;
    assign s_axi_acaddr  = '0;
    assign s_axi_acsnoop = 4'h0;
`endif

    assign w_aw_hs     = r_awready & s_axi_awvalid;
    assign w_ar_hs     = s_axi_arready & s_axi_arvalid;
    assign w_w_hs      = r_wready & s_axi_wvalid;
    assign w_r_hs      = r_rvalid & s_axi_rready;
    assign w_addr_next = next_addr(r_addr, r_size, r_len, r_burst);
    assign w_rd_addr   = (r_state == ST_IDLE) ? s_axi_araddr : w_addr_next;
    assign w_rd_ok     = in_range(w_rd_addr);
    assign w_rd_word   = w_rd_ok ? r_mem[word_idx(w_rd_addr)] : '0;
    assign w_wr_ok     = in_range(r_addr);

    // Memory is deliberately not reset so completed writes survive a reset.
    always_ff @(posedge clk) begin
        if (w_w_hs && w_wr_ok) begin
            for (int b = 0; b < STRB_WIDTH; b++) begin
                if (s_axi_wstrb[b]) begin
                    r_mem[word_idx(r_addr)][8*b +: 8] <= s_axi_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_id      <= '0;
            r_addr    <= '0;
            r_len     <= '0;
            r_size    <= '0;
            r_burst   <= '0;
            r_beat    <= '0;
            r_wr_err  <= 1'b0;
            r_awready <= 1'b0;
            r_arready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b0;
            r_bid     <= '0;
            r_bresp   <= 2'b00;
            r_rvalid  <= 1'b0;
            r_rid     <= '0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
            r_rlast   <= 1'b0;
`ifdef AXI_MEM_RESPONDER_SNOOP_EN
            r_acvalid  <= 1'b0;
            r_acaddr   <= '0;
            r_acsnoop  <= 4'h0;
            r_aw_first <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_aw_hs) begin
                        r_id      <= s_axi_awid;
                        r_addr    <= s_axi_awaddr;
                        r_len     <= s_axi_awlen;
                        r_size    <= s_axi_awsize;
                        r_burst   <= s_axi_awburst;
                        r_wr_err  <= 1'b0;
                        r_awready <= 1'b0;
                        r_arready <= 1'b0;
                        r_wready  <= 1'b1;
`ifdef AXI_MEM_RESPONDER_SNOOP_EN
                        r_aw_first <= s_axi_awaddr;
`endif
                        r_state   <= ST_WR_DATA;
                    end else if (w_ar_hs) begin
                        r_id      <= s_axi_arid;
                        r_addr    <= s_axi_araddr;
                        r_len     <= s_axi_arlen;
                        r_size    <= s_axi_arsize;
                        r_burst   <= s_axi_arburst;
                        r_beat    <= 8'd0;
                        r_awready <= 1'b0;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rid     <= s_axi_arid;
                        r_rdata   <= w_rd_word;
                        r_rresp   <= w_rd_ok ? 2'b00 : 2'b10;
                        r_rlast   <= (s_axi_arlen == 8'd0);
                        r_state   <= ST_RD_DATA;
                    end else begin
                        r_awready <= 1'b1;
                        r_arready <= 1'b1;
                    end
                end
                ST_RD_DATA: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid  <= 1'b0;
                            r_rlast   <= 1'b0;
                            r_awready <= 1'b1;
                            r_arready <= 1'b1;
                            r_state   <= ST_IDLE;
                        end else begin
                            r_addr  <= w_addr_next;
                            r_rdata <= w_rd_word;
                            r_rresp <= w_rd_ok ? 2'b00 : 2'b10;
                            r_beat  <= r_beat + 8'd1;
                            r_rlast <= ((r_beat + 8'd1) == r_len);
                        end
                    end
                end
                ST_WR_DATA: begin
                    // wlast alone terminates the burst; awlen only shapes WRAP.
                    if (w_w_hs) begin
                        if (!w_wr_ok) begin
                            r_wr_err <= 1'b1;
                        end
                        if (s_axi_wlast) begin
                            r_wready <= 1'b0;
                            r_bvalid <= 1'b1;
                            r_bid    <= r_id;
                            r_bresp  <= (r_wr_err || !w_wr_ok) ? 2'b10 : 2'b00;
                            r_state  <= ST_WR_RESP;
                        end else begin
                            r_addr <= w_addr_next;
                        end
                    end
                end
                ST_WR_RESP: begin
                    if (s_axi_bready) begin
                        r_bvalid <= 1'b0;
`ifdef AXI_MEM_RESPONDER_SNOOP_EN
                        r_acvalid <= 1'b1;
                        r_acaddr  <= {r_aw_first[ADDR_WIDTH-1:6], 6'b0};
                        r_acsnoop <= 4'hd;
                        r_state   <= ST_SNOOP;
`else
                        r_awready <= 1'b1;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
`endif
                    end
                end
`ifdef AXI_MEM_RESPONDER_SNOOP_EN
                ST_SNOOP: begin
                    if (s_axi_acready) begin
                        r_acvalid <= 1'b0;
                        r_awready <= 1'b1;
                        r_arready <= 1'b1;
                        r_state   <= ST_IDLE;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// Directed bench for axi_mem_responder: bursts, WRAP, strobes, range errors,
// arbitration, R stall, reset mid-burst and the optional snoop channel.
module tb_axi_mem_responder;

    logic        clk;
    logic        reset;
    logic [12:0] s_axi_awid;
    logic [63:0] s_axi_awaddr;
    logic [7:0]  s_axi_awlen;
    logic [2:0]  s_axi_awsize;
    logic [1:0]  s_axi_awburst;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [63:0] s_axi_wdata;
    logic [7:0]  s_axi_wstrb;
    logic        s_axi_wlast;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [12:0] s_axi_bid;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [12:0] s_axi_arid;
    logic [63:0] s_axi_araddr;
    logic [7:0]  s_axi_arlen;
    logic [2:0]  s_axi_arsize;
    logic [1:0]  s_axi_arburst;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [12:0] s_axi_rid;
    logic [63:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rlast;
    logic        s_axi_rvalid;
    logic        s_axi_rready;
    logic        s_axi_acvalid;
    logic [63:0] s_axi_acaddr;
    logic [3:0]  s_axi_acsnoop;
    logic        s_axi_acready;

    axi_mem_responder dut (
        .clk           (clk),
        .reset         (reset),
        .s_axi_awid    (s_axi_awid),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awlen   (s_axi_awlen),
        .s_axi_awsize  (s_axi_awsize),
        .s_axi_awburst (s_axi_awburst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wlast   (s_axi_wlast),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bid     (s_axi_bid),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_arid    (s_axi_arid),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arlen   (s_axi_arlen),
        .s_axi_arsize  (s_axi_arsize),
        .s_axi_arburst (s_axi_arburst),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rid     (s_axi_rid),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rlast   (s_axi_rlast),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_acvalid (s_axi_acvalid),
        .s_axi_acaddr  (s_axi_acaddr),
        .s_axi_acsnoop (s_axi_acsnoop),
        .s_axi_acready (s_axi_acready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    logic [63:0] wbuf [16];
    logic [63:0] rbuf [16];
    logic [1:0]  rresp_buf [16];
    logic        rlast_buf [16];
    logic [12:0] rid_buf [16];
    logic [1:0]  last_bresp;
    logic [12:0] last_bid;

    int ac_cycles = 0;
    bit in_simul  = 1'b0;
    int early_ar  = 0;
    always @(posedge clk) begin
        if (s_axi_acvalid) ac_cycles++;
        if (in_simul && s_axi_arvalid && s_axi_arready) early_ar++;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // All tasks start and end on a negedge; inputs change there, outputs sampled there.
    task automatic do_write(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [7:0] strb, input logic [12:0] id,
                            input int nbeats);
        int n;
        s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = len;
        s_axi_awsize = size; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("awready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < nbeats; i++) begin
            s_axi_wdata = wbuf[i]; s_axi_wstrb = strb;
            s_axi_wlast = (i == nbeats - 1); s_axi_wvalid = 1'b1;
            n = 0;
            while (!s_axi_wready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) chk("wready_timeout", 64'd0, 64'd1);
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0; s_axi_bready = 1'b1;
        n = 0;
        while (!s_axi_bvalid && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("bvalid_timeout", 64'd0, 64'd1);
        last_bresp = s_axi_bresp; last_bid = s_axi_bid;
        @(negedge clk);
        s_axi_bready = 1'b0;
    endtask

    task automatic do_read(input logic [63:0] addr, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic [12:0] id, input int nbeats,
                           input int stall_beat);
        int n;
        logic [63:0] hold;
        s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = len;
        s_axi_arsize = size; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
        n = 0;
        while (!s_axi_arready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("arready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        chk("first_rvalid_latency", {63'd0, s_axi_rvalid}, 64'd1);
        s_axi_rready = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            n = 0;
            while (!s_axi_rvalid && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) chk("rvalid_timeout", 64'd0, 64'd1);
            if (i == stall_beat) begin
                s_axi_rready = 1'b0;
                hold = s_axi_rdata;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    chk("stall_rdata", s_axi_rdata, hold);
                    chk("stall_rvalid", {63'd0, s_axi_rvalid}, 64'd1);
                end
                s_axi_rready = 1'b1;
            end
            rbuf[i] = s_axi_rdata; rresp_buf[i] = s_axi_rresp;
            rlast_buf[i] = s_axi_rlast; rid_buf[i] = s_axi_rid;
            @(negedge clk);
        end
        s_axi_rready = 1'b0;
    endtask

    initial begin
        int n;
        reset = 1'b1;
        s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0;
        s_axi_awburst = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0; s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0;
        s_axi_arburst = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        s_axi_acready = 1'b1;

        repeat (3) @(negedge clk);
        chk("rst_awready", {63'd0, s_axi_awready}, 64'd0);
        chk("rst_arready", {63'd0, s_axi_arready}, 64'd0);
        chk("rst_wready",  {63'd0, s_axi_wready},  64'd0);
        chk("rst_bvalid",  {63'd0, s_axi_bvalid},  64'd0);
        chk("rst_rvalid",  {63'd0, s_axi_rvalid},  64'd0);
        chk("rst_rdata",   s_axi_rdata, 64'd0);
        chk("rst_acvalid", {63'd0, s_axi_acvalid}, 64'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_awready", {63'd0, s_axi_awready}, 64'd1);
        chk("post_rst_arready", {63'd0, s_axi_arready}, 64'd1);

        // 8-beat INCR write then readback
        for (int i = 0; i < 8; i++) wbuf[i] = 64'(i + 1);
        do_write(64'h8000_0040, 8'd7, 3'd3, 2'b01, 8'hff, 13'h1A5, 8);
        chk("incr_bresp", {62'd0, last_bresp}, 64'd0);
        chk("incr_bid", {51'd0, last_bid}, 64'h1A5);
        do_read(64'h8000_0040, 8'd7, 3'd3, 2'b01, 13'h0F3, 8, -1);
        for (int i = 0; i < 8; i++) begin
            chk("incr_rdata", rbuf[i], 64'(i + 1));
            chk("incr_rlast", {63'd0, rlast_buf[i]}, (i == 7) ? 64'd1 : 64'd0);
            chk("incr_rid", {51'd0, rid_buf[i]}, 64'h0F3);
            chk("incr_rresp", {62'd0, rresp_buf[i]}, 64'd0);
        end

        // WRAP read starting mid-window: 4..8 then 1..3
        do_read(64'h8000_0058, 8'd7, 3'd3, 2'b10, 13'h002, 8, -1);
        for (int i = 0; i < 8; i++) begin
            chk("wrap_rdata", rbuf[i], 64'(((i + 3) % 8) + 1));
            chk("wrap_rlast", {63'd0, rlast_buf[i]}, (i == 7) ? 64'd1 : 64'd0);
        end

        // Byte-strobe merge
        wbuf[0] = 64'h1122_3344_5566_7788;
        do_write(64'h8000_0000, 8'd0, 3'd3, 2'b01, 8'hff, 13'h003, 1);
        wbuf[0] = 64'h0000_0000_0000_00AB;
        do_write(64'h8000_0000, 8'd0, 3'd0, 2'b01, 8'h01, 13'h004, 1);
        chk("strb_bresp", {62'd0, last_bresp}, 64'd0);
        do_read(64'h8000_0000, 8'd0, 3'd3, 2'b01, 13'h005, 1, -1);
        chk("strb_rdata", rbuf[0], 64'h1122_3344_5566_77AB);
        chk("strb_rlast", {63'd0, rlast_buf[0]}, 64'd1);

        // Out-of-range accesses
        do_read(64'h1000_0000, 8'd0, 3'd3, 2'b01, 13'h006, 1, -1);
        chk("oor_rresp", {62'd0, rresp_buf[0]}, 64'd2);
        chk("oor_rdata", rbuf[0], 64'd0);
        wbuf[0] = 64'hFFFF_FFFF_FFFF_FFFF;
        do_write(64'h1000_0000, 8'd0, 3'd3, 2'b01, 8'hff, 13'h007, 1);
        chk("oor_bresp", {62'd0, last_bresp}, 64'd2);
        chk("oor_bid", {51'd0, last_bid}, 64'h007);
        do_read(64'h1000_0000, 8'd0, 3'd3, 2'b01, 13'h006, 1, -1);
        chk("oor_reread", rbuf[0], 64'd0);
        do_read(64'h8000_0000, 8'd0, 3'd3, 2'b01, 13'h006, 1, -1);
        chk("oor_mem_intact", rbuf[0], 64'h1122_3344_5566_77AB);
        do_read(64'h7FFF_FFF8, 8'd0, 3'd3, 2'b01, 13'h006, 1, -1);
        chk("below_base_rresp", {62'd0, rresp_buf[0]}, 64'd2);

        // Burst straddling the top of memory: first beat lands, second errs
        wbuf[0] = 64'h0C0C_0C0C_0C0C_0C0C;
        wbuf[1] = 64'hDDDD_DDDD_DDDD_DDDD;
        do_write(64'h8000_7FF8, 8'd1, 3'd3, 2'b01, 8'hff, 13'h008, 2);
        chk("edge_bresp", {62'd0, last_bresp}, 64'd2);
        do_read(64'h8000_7FF8, 8'd1, 3'd3, 2'b01, 13'h009, 2, -1);
        chk("edge_last_word", rbuf[0], 64'h0C0C_0C0C_0C0C_0C0C);
        chk("edge_last_rresp", {62'd0, rresp_buf[0]}, 64'd0);
        chk("edge_past_rdata", rbuf[1], 64'd0);
        chk("edge_past_rresp", {62'd0, rresp_buf[1]}, 64'd2);

        // FIXED burst: every beat hits the same word
        wbuf[0] = 64'h11; wbuf[1] = 64'h22; wbuf[2] = 64'h33;
        do_write(64'h8000_0300, 8'd2, 3'd3, 2'b00, 8'hff, 13'h00A, 3);
        do_read(64'h8000_0300, 8'd1, 3'd3, 2'b00, 13'h00B, 2, -1);
        chk("fixed_beat0", rbuf[0], 64'h33);
        chk("fixed_beat1", rbuf[1], 64'h33);

        // Simultaneous AW/AR: write wins, read waits; then stall R mid-burst
        s_axi_arid = 13'h00C; s_axi_araddr = 64'h8000_0040; s_axi_arlen = 8'd3;
        s_axi_arsize = 3'd3; s_axi_arburst = 2'b01; s_axi_arvalid = 1'b1;
        s_axi_awaddr = 64'h8000_0100; s_axi_awvalid = 1'b1;
        in_simul = 1'b1;
        #1;
        chk("simul_awready", {63'd0, s_axi_awready}, 64'd1);
        chk("simul_arready", {63'd0, s_axi_arready}, 64'd0);
        wbuf[0] = 64'h55;
        do_write(64'h8000_0100, 8'd0, 3'd3, 2'b01, 8'hff, 13'h00D, 1);
        in_simul = 1'b0;
        chk("simul_no_early_ar", 64'(early_ar), 64'd0);
        chk("simul_bid", {51'd0, last_bid}, 64'h00D);
        do_read(64'h8000_0040, 8'd3, 3'd3, 2'b01, 13'h00C, 4, 2);
        for (int i = 0; i < 4; i++) chk("stall_burst_rdata", rbuf[i], 64'(i + 1));
        chk("stall_burst_rlast", {63'd0, rlast_buf[3]}, 64'd1);

        // Reset in the middle of a write burst
        for (int i = 0; i < 4; i++) wbuf[i] = 64'hA0 + 64'(i);
        do_write(64'h8000_0200, 8'd3, 3'd3, 2'b01, 8'hff, 13'h00E, 4);
        s_axi_awid = 13'h00F; s_axi_awaddr = 64'h8000_0200; s_axi_awlen = 8'd3;
        s_axi_awsize = 3'd3; s_axi_awburst = 2'b01; s_axi_awvalid = 1'b1;
        n = 0;
        while (!s_axi_awready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("abort_awready_timeout", 64'd0, 64'd1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_axi_wdata = 64'hB0 + 64'(i); s_axi_wstrb = 8'hff;
            s_axi_wlast = 1'b0; s_axi_wvalid = 1'b1;
            @(negedge clk);
        end
        s_axi_wvalid = 1'b0;
        reset = 1'b1;
        #1;
        chk("abort_wready", {63'd0, s_axi_wready}, 64'd0);
        chk("abort_bvalid", {63'd0, s_axi_bvalid}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_idle_awready", {63'd0, s_axi_awready}, 64'd1);
        do_read(64'h8000_0200, 8'd3, 3'd3, 2'b01, 13'h010, 4, -1);
        chk("abort_beat0", rbuf[0], 64'hB0);
        chk("abort_beat1", rbuf[1], 64'hB1);
        chk("abort_beat2", rbuf[2], 64'hA2);
        chk("abort_beat3", rbuf[3], 64'hA3);

        // Snoop after write
        wbuf[0] = 64'hDEAD;
`ifdef AXI_MEM_RESPONDER_SNOOP_EN
        s_axi_acready = 1'b0;
        do_write(64'h8000_0048, 8'd0, 3'd3, 2'b01, 8'hff, 13'h011, 1);
        for (int k = 0; k < 3; k++) begin
            chk("snoop_acvalid", {63'd0, s_axi_acvalid}, 64'd1);
            chk("snoop_acaddr", s_axi_acaddr, 64'h8000_0040);
            chk("snoop_acsnoop", {60'd0, s_axi_acsnoop}, 64'hd);
            @(negedge clk);
        end
        s_axi_acready = 1'b1;
        @(negedge clk);
        chk("snoop_done", {63'd0, s_axi_acvalid}, 64'd0);
`else
        do_write(64'h8000_0048, 8'd0, 3'd3, 2'b01, 8'hff, 13'h011, 1);
        repeat (3) @(negedge clk);
        chk("no_snoop_acvalid", 64'(ac_cycles), 64'd0);
`endif
        do_read(64'h8000_0048, 8'd0, 3'd3, 2'b01, 13'h012, 1, -1);
        chk("snoop_write_data", rbuf[0], 64'hDEAD);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_mem_responder.md
AXI_MEM_RESPONDER -- requirements
Module: axi_mem_responder

Interface
REQ-001 SHALL have parameter ID_WIDTH, default 13, AXI ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 64, data width; STRB_WIDTH = DATA_WIDTH/8.
REQ-004 SHALL have parameter MEM_WORDS, default 4096, backing-store depth in 64-bit words.
REQ-005 SHALL have parameter BASE_ADDR, default 64'h80000000, first byte address served.
REQ-006 Ports, one per line:
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  asynchronous, active-high reset.
- s_axi_aw{id,addr,len,size,burst,valid}  in  ID_WIDTH/ADDR_WIDTH/8/3/2/1  write address; s_axi_awready out 1.
- s_axi_w{data,strb,last,valid}  in  DATA_WIDTH/STRB_WIDTH/1/1  write data; s_axi_wready out 1.
- s_axi_b{id,resp,valid}  out  ID_WIDTH/2/1  write response; s_axi_bready in 1.
- s_axi_ar{id,addr,len,size,burst,valid}  in  as AW  read address; s_axi_arready out 1.
- s_axi_r{id,data,resp,last,valid}  out  ID_WIDTH/DATA_WIDTH/2/1/1  read data; s_axi_rready in 1.
- s_axi_ac{valid,addr,snoop}  out  1/ADDR_WIDTH/4  snoop request to caching master; s_axi_acready in 1.

Function
REQ-007 SHALL serve one transaction at a time; FSM states IDLE, RD_DATA, WR_DATA, WR_RESP, SNOOP.
REQ-008 arready and awready SHALL be high only in IDLE; when awvalid and arvalid are both high in IDLE, write SHALL win.
REQ-009 AR handshake: capture id/addr/len/size/burst, go RD_DATA; first rvalid SHALL be asserted the following cycle.
REQ-010 RD_DATA: rdata = full 64-bit word at addr[..:3]; rid = captured id; rlast high on beat len; rvalid/rdata/rlast held stable while rready low.
REQ-011 Beat address advance: burst 0 FIXED = unchanged; 1 INCR = +2^size; 2 WRAP = +2^size, wrapping within aligned (len+1)*2^size window.
REQ-012 After rlast handshake SHALL return to IDLE.
REQ-013 AW handshake: capture fields, go WR_DATA; wready SHALL be high throughout WR_DATA.
REQ-014 Each W handshake SHALL write only bytes with wstrb set; address advances per REQ-011.
REQ-015 On W handshake with wlast, go WR_RESP; bvalid high, bid = captured awid, held until bready.
REQ-016 Beat address outside [BASE_ADDR, BASE_ADDR+8*MEM_WORDS): read returns rdata 0, rresp 2'b10; write dropped, bresp 2'b10 if any beat erred; otherwise resp 2'b00.
REQ-017 wlast early/late relative to awlen SHALL be ignored; wlast alone ends the burst.
REQ-018 After B handshake: with snoop feature, go SNOOP; otherwise IDLE.
REQ-019 SNOOP: acvalid high, acaddr = awaddr with low 6 bits cleared, acsnoop = 4'hd, held until acready, then IDLE.

Reset
REQ-020 reset SHALL asynchronously force IDLE and deassert awready, wready, bvalid, arready, rvalid, rlast, acvalid; bid, rid, bresp, rresp, rdata, acaddr, acsnoop = 0.
REQ-021 Reset mid-burst SHALL abandon the transaction; memory contents are not cleared; writes already completed persist.
REQ-022 First cycle after reset release SHALL be IDLE with arready/awready high.

Configuration
REQ-023 Macro AXI_MEM_RESPONDER_SNOOP_EN defined: SNOOP state and REQ-019 present. Undefined: SNOOP state absent, acvalid tied 0, acaddr/acsnoop tied 0, B handshake returns to IDLE.

Verification
REQ-024 Write 8-beat INCR, awaddr 0x80000040, size 3, wstrb 0xff, data 1..8 -> bresp 0, bid = awid; readback INCR len 7 returns 1..8, rlast on beat 8.
REQ-025 WRAP read araddr 0x80000058, len 7, size 3 after REQ-024 -> data 4,5,6,7,8,1,2,3; rlast on 8th beat.
REQ-026 Single-beat write addr 0x80000000, size 0, wstrb 0x01, data 0xAB over preloaded 0x1122334455667788 -> readback 0x11223344556677AB.
REQ-027 Read addr 0x10000000 len 0 -> rresp 2'b10, rdata 0; write there -> bresp 2'b10, memory unchanged.
REQ-028 Simultaneous awvalid/arvalid in IDLE -> awready first, arready only after B (and snoop) complete; rready held low 5 cycles mid-burst -> rdata stable.
REQ-029 With AXI_MEM_RESPONDER_SNOOP_EN, write to 0x80000048 -> acvalid with acaddr 0x80000040, acsnoop 4'hd, held 3 cycles until acready; without macro acvalid never asserts.
